// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data_mem block: controller FSM state encoding
// and the legal read-latency values.
// -----------------------------------------------------------------------------
package data_mem_pkg;

  // Controller states. CLEAR exists only when DATA_MEM_CLEAR_EN is defined.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Legal read latencies in clock cycles.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Map the RD_LAT parameter onto the number of read-valid stages.
  // Anything at or above the maximum builds the two-stage pipeline.
  function automatic int rd_lat_stages(input int rd_lat);
    if (rd_lat >= RD_LAT_MAX) return RD_LAT_MAX;
    return RD_LAT_MIN;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// -----------------------------------------------------------------------------
// data_mem_if
// Request/response bundle of the data_mem block.
//   REQ, WR, Address, Din, BE : request from the master
//   READY                     : memory accepting requests
//   Dout, DVALID              : read data and its one-cycle valid pulse
//   BUSY                      : initialisation clear in progress
// -----------------------------------------------------------------------------
interface data_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);

  logic                  REQ;
  logic                  WR;
  logic [ADDR_W-1:0]     Address;
  logic [DATA_W-1:0]     Din;
  logic [DATA_W/8-1:0]   BE;
  logic                  READY;
  logic [DATA_W-1:0]     Dout;
  logic                  DVALID;
  logic                  BUSY;

  modport master (
    output REQ, WR, Address, Din, BE,
    input  READY, Dout, DVALID, BUSY
  );

  modport slave (
    input  REQ, WR, Address, Din, BE,
    output READY, Dout, DVALID, BUSY
  );

endinterface

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// Single-port storage with per-byte write enables and a registered
// (synchronous) read port.
//   i_clk, i_rst_n : clock and async active-low reset (read register only)
//   i_we, i_be     : write strobe and byte enables
//   i_re           : read strobe; o_q updates only on an enabled read
//   i_addr, i_din  : word address and write data
//   o_q            : registered read data, held between reads
// -----------------------------------------------------------------------------
module data_mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic                i_re,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_din,
  output logic [DATA_W-1:0]   o_q
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // NOTE: the storage array has no reset so it can map onto RAM; only the
  // read-data register below is reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_din[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state is always assigned with non-blocking (<=) so all
  // flops sample their inputs from before the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_q <= '0;
    else if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Byte-writable single-port data memory with pipelined reads.
//   CLK    : clock, all state on the rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : data_mem_if slave (REQ/WR/Address/Din/BE in,
//            READY/Dout/DVALID/BUSY out)
// Parameters: DATA_W (multiple of 8), ADDR_W (depth 2**ADDR_W), RD_LAT (1|2).
// Build option: define DATA_MEM_CLEAR_EN to zero the whole array after every
// reset (BUSY high, READY low while clearing). Without it BUSY is tied low and
// the memory powers up with undefined contents.
// -----------------------------------------------------------------------------
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic    CLK,
  input  logic    RST_N,
  data_mem_if.slave bus
);

  localparam int BE_W   = DATA_W / 8;
  localparam int STAGES = rd_lat_stages(RD_LAT);

  logic                w_ready;
  logic                w_busy;
  logic                w_accept;
  logic                w_rd_acc;
  logic                w_wr_acc;

  logic                w_arr_we;
  logic [ADDR_W-1:0]   w_arr_addr;
  logic [BE_W-1:0]     w_arr_be;
  logic [DATA_W-1:0]   w_arr_din;
  logic [DATA_W-1:0]   w_arr_q;

  // Requests presented while READY is low are simply dropped.
  assign w_accept = bus.REQ & w_ready;
  assign w_rd_acc = w_accept & ~bus.WR;
  assign w_wr_acc = w_accept &  bus.WR;

`ifdef DATA_MEM_CLEAR_EN
  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_addr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_CLEAR;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_addr == '1) w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // Clear pointer walks 0..2**ADDR_W-1; reset always restarts it at 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                   r_clr_addr <= '0;
    else if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + ADDR_W'(1);
  end

  assign w_busy  = (r_state == ST_CLEAR);
  assign w_ready = (r_state == ST_RUN);

  // While clearing, the array port is owned by the clear pointer.
  always_comb begin
    w_arr_we   = w_wr_acc;
    w_arr_addr = bus.Address;
    w_arr_be   = bus.BE;
    w_arr_din  = bus.Din;
    if (w_busy) begin
      w_arr_we   = 1'b1;
      w_arr_addr = r_clr_addr;
      w_arr_be   = '1;
      w_arr_din  = '0;
    end
  end
`else
  logic r_ready;

  // READY rises on the first edge after reset is released.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_ready <= 1'b0;
    else        r_ready <= 1'b1;
  end

  assign w_busy     = 1'b0;
  assign w_ready    = r_ready;
  assign w_arr_we   = w_wr_acc;
  assign w_arr_addr = bus.Address;
  assign w_arr_be   = bus.BE;
  assign w_arr_din  = bus.Din;
`endif

  data_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_we    (w_arr_we),
    .i_re    (w_rd_acc),
    .i_addr  (w_arr_addr),
    .i_be    (w_arr_be),
    .i_din   (w_arr_din),
    .o_q     (w_arr_q)
  );

  // Stage 1 valid: marks array read data registered on the accepting edge.
  logic r_vld1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_vld1 <= 1'b0;
    else        r_vld1 <= w_rd_acc;
  end

  generate
    if (STAGES == 2) begin : g_lat2
      logic              r_vld2;
      logic [DATA_W-1:0] r_dout2;

      // Output register loads only on a valid read, so Dout holds otherwise.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_vld2  <= 1'b0;
          r_dout2 <= '0;
        end else begin
          r_vld2 <= r_vld1;
          if (r_vld1) r_dout2 <= w_arr_q;
        end
      end

      assign bus.Dout   = r_dout2;
      assign bus.DVALID = r_vld2;
    end else begin : g_lat1
      // The array read register already holds between reads and resets to 0.
      assign bus.Dout   = w_arr_q;
      assign bus.DVALID = r_vld1;
    end
  endgenerate

  assign bus.READY = w_ready;
  assign bus.BUSY  = w_busy;

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
// Drives identical directed traffic into two data_mem instances (RD_LAT=1 and
// RD_LAT=2, ADDR_W=4). Reads push {data, due cycle} into a per-instance queue;
// a monitor per instance pops and compares on every DVALID pulse.
// -----------------------------------------------------------------------------
module tb_data_mem;

  localparam int DW = 16;
  localparam int AW = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  data_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  data_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  data_mem #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1)
  );

  data_mem #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_dut2 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus2)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
    int            addr;
  } exp_t;

  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] model [16];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  logic [DW-1:0] last_rd;

  // Edge counter: after rising edge N, cyc == N.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare data and arrival cycle on each DVALID pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (bus1.DVALID === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected DVALID", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check($sformatf("dut1 read data addr %0d", e.addr), 32'(bus1.Dout), 32'(e.data));
        check($sformatf("dut1 read cycle addr %0d", e.addr), 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (bus2.DVALID === 1'b1) begin
      if (q2.size() == 0) begin
        check("dut2 unexpected DVALID", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check($sformatf("dut2 read data addr %0d", e.addr), 32'(bus2.Dout), 32'(e.data));
        check($sformatf("dut2 read cycle addr %0d", e.addr), 32'(cyc), 32'(e.due));
      end
    end
  end

  // One bus cycle: drive at the falling edge, update model / expectations,
  // return just after the rising edge that may accept the request.
  task automatic op(input bit req, input bit wr, input int addr,
                    input logic [DW-1:0] din, input logic [1:0] be);
    int a;
    a = addr & 15;
    @(negedge CLK);
    bus1.REQ = req; bus1.WR = wr; bus1.Address = 4'(a); bus1.Din = din; bus1.BE = be;
    bus2.REQ = req; bus2.WR = wr; bus2.Address = 4'(a); bus2.Din = din; bus2.BE = be;
    if (req && bus1.READY === 1'b1) begin
      if (wr) begin
        if (be[0]) model[a][7:0]  = din[7:0];
        if (be[1]) model[a][15:8] = din[15:8];
      end else begin
        q1.push_back('{data: model[a], due: cyc + 1, addr: a});
      end
    end
    if (req && !wr && bus2.READY === 1'b1)
      q2.push_back('{data: model[a], due: cyc + 2, addr: a});
    @(posedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 1'b0, 0, '0, 2'b00);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus1.READY !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " dut1 READY"}, 32'(bus1.READY), 32'd1);
    check({tag, " dut2 READY"}, 32'(bus2.READY), 32'd1);
  endtask

`ifdef DATA_MEM_CLEAR_EN
  // Called at the falling edge where reset is released; counts BUSY cycles.
  task automatic measure_clear(input string tag);
    int n;
    n = 0;
    for (int a = 0; a < 16; a++) model[a] = '0;
    while (bus1.BUSY === 1'b1 && n < 100) begin
      check({tag, " READY low while BUSY"}, 32'(bus1.READY), 32'd0);
      n++;
      @(negedge CLK);
    end
    bus1.REQ = 1'b0;
    bus2.REQ = 1'b0;
    check({tag, " busy cycles"}, 32'(n), 32'd16);
    check({tag, " dut1 READY"}, 32'(bus1.READY), 32'd1);
    check({tag, " dut2 BUSY"}, 32'(bus2.BUSY), 32'd0);
  endtask
`endif

  initial begin
    bus1.REQ = 1'b0; bus1.WR = 1'b0; bus1.Address = '0; bus1.Din = '0; bus1.BE = '0;
    bus2.REQ = 1'b0; bus2.WR = 1'b0; bus2.Address = '0; bus2.Din = '0; bus2.BE = '0;
    for (int a = 0; a < 16; a++) model[a] = 'x;

    // Reset state.
    repeat (3) @(negedge CLK);
    check("reset dut1 Dout",   32'(bus1.Dout),   32'd0);
    check("reset dut1 DVALID", 32'(bus1.DVALID), 32'd0);
    check("reset dut1 READY",  32'(bus1.READY),  32'd0);
    check("reset dut2 Dout",   32'(bus2.Dout),   32'd0);
    check("reset dut2 DVALID", 32'(bus2.DVALID), 32'd0);
`ifdef DATA_MEM_CLEAR_EN
    check("reset dut1 BUSY", 32'(bus1.BUSY), 32'd1);
`else
    check("reset dut1 BUSY", 32'(bus1.BUSY), 32'd0);
`endif
    RST_N = 1'b1;

`ifdef DATA_MEM_CLEAR_EN
    measure_clear("clear");
    for (int a = 0; a < 16; a++) op(1'b1, 1'b0, a, '0, 2'b00);
    idle(3);

    // Reset in the middle of the clear (pointer at 9), with a write
    // requested throughout that must be ignored.
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (9) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    check("mid-clear reset BUSY", 32'(bus1.BUSY), 32'd1);
    bus1.REQ = 1'b1; bus1.WR = 1'b1; bus1.Address = 4'd2; bus1.Din = 16'hFFFF; bus1.BE = 2'b11;
    bus2.REQ = 1'b1; bus2.WR = 1'b1; bus2.Address = 4'd2; bus2.Din = 16'hFFFF; bus2.BE = 2'b11;
    RST_N = 1'b1;
    measure_clear("restart");
    op(1'b1, 1'b0, 2, '0, 2'b00);
    idle(3);
`else
    wait_ready("post-reset");
`endif

    // Known base value for the wrap test.
    op(1'b1, 1'b1, 0, 16'h1111, 2'b11);
    // Byte-enable merge.
    op(1'b1, 1'b1, 5, 16'hABCD, 2'b11);
    op(1'b1, 1'b1, 5, 16'h1234, 2'b01);
    op(1'b1, 1'b0, 5, '0, 2'b00);
    // Read immediately after write to the same address.
    op(1'b1, 1'b1, 3, 16'h55AA, 2'b11);
    op(1'b1, 1'b0, 3, '0, 2'b00);
    // Latency and hold.
    op(1'b1, 1'b1, 1, 16'h0F0F, 2'b11);
    op(1'b1, 1'b0, 1, '0, 2'b00);
    idle(3);
    @(negedge CLK);
    check("hold dut1 Dout 0F0F", 32'(bus1.Dout), 32'h0F0F);
    check("hold dut2 Dout 0F0F", 32'(bus2.Dout), 32'h0F0F);
    // Fill remaining low addresses.
    op(1'b1, 1'b1, 2, 16'h2222, 2'b11);
    op(1'b1, 1'b1, 4, 16'h4444, 2'b11);
    op(1'b1, 1'b1, 6, 16'h6666, 2'b11);
    op(1'b1, 1'b1, 7, 16'h7777, 2'b11);
    // Top address, then check address 0 is untouched.
    op(1'b1, 1'b1, 15, 16'hBEEF, 2'b11);
    op(1'b1, 1'b0, 15, '0, 2'b00);
    op(1'b1, 1'b0, 0, '0, 2'b00);
    // Back-to-back reads 0..7.
    for (int a = 0; a < 8; a++) op(1'b1, 1'b0, a, '0, 2'b00);
    last_rd = model[7];
    // A write must not disturb Dout.
    op(1'b1, 1'b1, 7, 16'h9999, 2'b11);
    idle(3);
    @(negedge CLK);
    check("write keeps dut1 Dout", 32'(bus1.Dout), 32'(last_rd));
    check("write keeps dut2 Dout", 32'(bus2.Dout), 32'(last_rd));
    check("no DVALID on write",    32'(bus1.DVALID), 32'd0);

    // Reset with two reads in flight: both are flushed.
    op(1'b1, 1'b0, 1, '0, 2'b00);
    op(1'b1, 1'b0, 2, '0, 2'b00);
    #1;
    RST_N = 1'b0;
    q1.delete();
    q2.delete();
    bus1.REQ = 1'b0;
    bus2.REQ = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      check("flush dut1 DVALID", 32'(bus1.DVALID), 32'd0);
      check("flush dut2 DVALID", 32'(bus2.DVALID), 32'd0);
      check("flush dut1 Dout",   32'(bus1.Dout),   32'd0);
      check("flush dut2 Dout",   32'(bus2.Dout),   32'd0);
    end
    RST_N = 1'b1;
`ifdef DATA_MEM_CLEAR_EN
    measure_clear("second clear");
`else
    wait_ready("after flush");
`endif
    // Contents survive reset unless cleared.
    op(1'b1, 1'b0, 5, '0, 2'b00);
    op(1'b1, 1'b0, 15, '0, 2'b00);
    idle(5);

    check("dut1 reads outstanding", 32'(q1.size()), 32'd0);
    check("dut2 reads outstanding", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, data word width in bits; multiple of 8.
REQ-002 SHALL provide parameter ADDR_W, default 10, word-address width; depth = 2**ADDR_W words.
REQ-003 SHALL provide parameter RD_LAT, default 1, read latency in cycles; legal values 1 and 2.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port REQ  input  1  access request.
REQ-007 SHALL have port WR  input  1  access type: 1 = write, 0 = read; sampled with REQ.
REQ-008 SHALL have port Address  input  ADDR_W  word address.
REQ-009 SHALL have port Din  input  DATA_W  write data.
REQ-010 SHALL have port BE  input  DATA_W/8  byte enables for writes; bit i covers Din[8i+7:8i].
REQ-011 SHALL have port READY  output  1  accepting requests.
REQ-012 SHALL have port Dout  output  DATA_W  read data.
REQ-013 SHALL have port DVALID  output  1  one-cycle pulse marking new Dout.
REQ-014 SHALL have port BUSY  output  1  initialisation clear in progress.

Function
REQ-015 A request SHALL be accepted on a rising edge where REQ=1 and READY=1; REQ while READY=0 SHALL be ignored with no effect.
REQ-016 An accepted write SHALL update only the bytes with BE=1 at that edge; BE=0 bytes keep old contents; write SHALL NOT pulse DVALID.
REQ-017 An accepted read SHALL present the addressed word on Dout with DVALID=1 exactly RD_LAT cycles after the accepting edge.
REQ-018 Reads SHALL be fully pipelined: one accepted request per cycle, READY=1 continuously outside clear.
REQ-019 A read accepted the cycle after a write to the same address SHALL return the newly written data (including partial-byte merge).
REQ-020 Dout SHALL hold its last read value while DVALID=0; writes SHALL NOT alter Dout.
REQ-021 Address SHALL wrap modulo 2**ADDR_W; no out-of-range condition exists.
REQ-022 Controller FSM states: CLEAR, RUN; CLEAR -> RUN after the last word is cleared; RUN is terminal until reset.

Reset
REQ-023 On RST_N=0: Dout=0, DVALID=0, in-flight read pipeline flushed (no DVALID for reads accepted before reset), clear counter=0.
REQ-024 Memory array contents SHALL NOT be reset by RST_N except via the clear feature.
REQ-025 Reset asserted mid-clear SHALL restart the clear from address 0 after deassertion.
REQ-026 After reset deassertion FSM SHALL enter CLEAR (macro defined) or RUN (macro undefined).

Configuration
REQ-027 Macro DATA_MEM_CLEAR_EN defined: in CLEAR, one word per cycle written to zero, addresses 0..2**ADDR_W-1 ascending; BUSY=1, READY=0 throughout; RUN entered the cycle after address 2**ADDR_W-1 is written; BUSY=0, READY=1 from then.
REQ-028 Macro DATA_MEM_CLEAR_EN undefined: no clear counter or CLEAR state logic; BUSY tied 0; READY=1 from the first edge after reset deassertion; initial contents undefined.

Structure
REQ-029 A shared package data_mem_pkg SHALL hold the FSM state enumeration and the RD_LAT legal-value constants.
REQ-030 Storage SHALL be a sub-module data_mem_array (single-port, byte-write, synchronous read) instantiated once; FSM, clear counter and read-valid pipeline reside in data_mem.

Verification
REQ-031 Clear: DATA_MEM_CLEAR_EN, ADDR_W=4, release reset -> BUSY=1/READY=0 for 16 cycles, then READY=1; read every address -> Dout=0.
REQ-032 Byte write: write 0xABCD BE=11 to addr 5, then 0x1234 BE=01 -> read addr 5 gives Dout=0xAB34, DVALID at RD_LAT cycles.
REQ-033 Back-to-back: write 0x55AA addr 3, next cycle read addr 3 -> Dout=0x55AA; reads to addr 0..7 on consecutive cycles -> 8 consecutive DVALID pulses in order.
REQ-034 Latency: RD_LAT=2, read addr 1 holding 0x0F0F -> DVALID high exactly 2 cycles after acceptance; Dout holds 0x0F0F after.
REQ-035 Reset mid-operation: assert RST_N=0 with two reads in flight -> DVALID stays 0, Dout=0; reset during clear at address 9 -> clear restarts at 0, lasts full 16 cycles.
REQ-036 Wrap/ignore: ADDR_W=4, REQ during BUSY=1 -> no write observed later; address 0xF write then read -> correct data, address 0x0 unaffected.
